histogram: RTL and testbench

count occurrences of each 8-bit value among v0[0..4095] and write count[b] to v1[b] for b=0..255.

REQ-004 States SHALL be IDLE, READ, DRAIN and WRITE.

REQ-005 In IDLE, when tstart=1 at an edge, all 256 internal 32-bit counters SHALL clear to 0 on that edge, the read index SHALL go to 0, and the state SHALL go to READ.

REQ-006 tstart SHALL be ignored in every state except IDLE.

REQ-007 READ SHALL last 4096 consecutive cycles with v0_rd_en=1 and v0_addr=0,1,...,4095, one address per cycle, ascending, no gaps.

REQ-008 Read latency is 1 cycle: v0_rd_data for the address presented in cycle k SHALL be valid in cycle k+1 and SHALL be sampled at the end of cycle k+1.

REQ-009 Each sampled byte d SHALL increment count[d] by 1 on the sampling edge.
- Consecutive equal bytes SHALL each be counted; no read-modify-write hazard is permitted, since counters are a flop array with single-cycle update.

REQ-010 After address 4095 is issued, the state SHALL go to DRAIN for 1 cycle with v0_rd_en=0, during which the final byte is sampled and counted.

REQ-011 WRITE SHALL last 256 consecutive cycles with v1_wr_en=1, v1_addr=0..255 ascending, and v1_wr_data=count[v1_addr].
- Data SHALL include the final byte's increment.

REQ-012 After bin 255 is written, the state SHALL return to IDLE with v1_wr_en=0.

REQ-013 Run latency: first v0_rd_en is in the cycle after the tstart edge; first v1_wr_en is 4097 cycles after the first v0_rd_en; the total busy span is 4096+1+256 cycles.

REQ-014 Outside READ, v0_rd_en SHALL be 0; outside WRITE, v1_wr_en SHALL be 0.

REQ-015 Address outputs hold their last value when their enable is 0; their value then has no meaning.

REQ-016 Counts SHALL be 32-bit unsigned; the maximum is 4096, so no overflow handling is needed.

REQ-017 A new tstart in IDLE after a run SHALL start a fresh run; counters clear, with no accumulation across runs.

Reset
REQ-018 rst=1 at an edge SHALL take precedence over all other activity, including tstart.

REQ-019 On reset: state=IDLE; v0_rd_en=0; v1_wr_en=0; v0_addr=0; v1_addr=0; v1_wr_data=0; read and write indices=0.
- Counters need not be cleared, because REQ-005 clears them on start.

REQ-020 Reset during READ, DRAIN or WRITE SHALL abort the run.
- All enables SHALL be 0 from the cycle after the reset edge.
- No further v1 writes occur until a new tstart.

Verification
REQ-021 Data = (addr==3 ? 5 : 1), one tstart pulse:
- 4096 reads, addresses 0..4095;
- then 256 writes: v1[1]=4095, v1[5]=1, all other bins 0.

REQ-022 All data 0: v1[0]=4096 and bins 1..255 = 0; the first write comes exactly 4097 cycles after the first read.

REQ-023 Data = addr[7:0]: every bin = 16; writes occur in ascending order, one per cycle, with no gaps.

REQ-024 Two back-to-back runs with different data: the second run's results reflect only the second data set, and tstart pulses during the first run are ignored.

REQ-025 Assert rst mid-READ (e.g. at address 2000), then wait 300 cycles:
- no v1 writes occur and enables stay 0;
- a subsequent tstart gives correct results.

REQ-026 tstart and rst high on the same edge: the block stays IDLE with no reads.

---
 rtl/histogram.sv | 94 +++++++++
 tb/tb_histogram.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/histogram.sv
// histogram: byte-value histogram over a 4096-entry input memory.
//   On tstart (in IDLE), the block clears all 256 bin counters. It then reads
//   v0[0..4095], one address per cycle, and counts every byte it reads.
//   Finally it writes count[b] to v1[b] for b = 0..255, one bin per cycle.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   tstart     - start pulse, honoured only in IDLE
//   v0_addr    - input-memory read address (12 bits)
//   v0_rd_en   - input-memory read enable
//   v0_rd_data - input-memory read data, valid one cycle after the address
//   v1_addr    - result-memory write address (bin, 8 bits)
//   v1_wr_en   - result-memory write enable
//   v1_wr_data - result-memory write data (32-bit bin count)
module histogram (
    input  logic        clk,
    input  logic        rst,
    input  logic        tstart,
    output logic [11:0] v0_addr,
    output logic        v0_rd_en,
    input  logic [7:0]  v0_rd_data,
    output logic [7:0]  v1_addr,
    output logic        v1_wr_en,
    output logic [31:0] v1_wr_data
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    state_t      r_state;
    logic        r_smp;               // read data on v0_rd_data is valid this cycle
    logic [31:0] r_cnt [0:255];
    logic [7:0]  w_next_bin;
    logic [31:0] w_bin0_fix;

    assign w_next_bin = v1_addr + 8'd1;
    // The last byte is counted on the same edge that loads bin 0 for output.
    // Fold that increment in so the first write sees it.
    assign w_bin0_fix = {31'd0, (r_smp && (v0_rd_data == 8'd0))};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_smp      <= 1'b0;
            v0_addr    <= 12'd0;
            v0_rd_en   <= 1'b0;
            v1_addr    <= 8'd0;
            v1_wr_en   <= 1'b0;
            v1_wr_data <= 32'd0;
        end else begin
            r_smp <= v0_rd_en;
            // Single-cycle update of a flop array, so equal consecutive bytes
            // need no forwarding.
            if (r_smp)
                r_cnt[v0_rd_data] <= r_cnt[v0_rd_data] + 32'd1;

            case (r_state)
                IDLE: begin
                    if (tstart) begin
                        for (int i = 0; i < 256; i++)
                            r_cnt[i] <= 32'd0;
                        v0_addr  <= 12'd0;
                        v0_rd_en <= 1'b1;
                        r_state  <= READ;
                    end
                end
                READ: begin
                    if (v0_addr == 12'hFFF) begin
                        v0_rd_en <= 1'b0;
                        r_state  <= DRAIN;
                    end else begin
                        v0_addr <= v0_addr + 12'd1;
                    end
                end
                DRAIN: begin
                    v1_addr    <= 8'd0;
                    v1_wr_en   <= 1'b1;
                    v1_wr_data <= r_cnt[0] + w_bin0_fix;
                    r_state    <= WRITE;
                end
                WRITE: begin
                    if (v1_addr == 8'hFF) begin
                        v1_wr_en <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        v1_addr    <= w_next_bin;
                        v1_wr_data <= r_cnt[w_next_bin];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_histogram.sv
module tb_histogram;

    logic        clk = 1'b0;
    logic        rst;
    logic        tstart;
    logic [11:0] v0_addr;
    logic        v0_rd_en;
    logic [7:0]  v0_rd_data = 8'd0;
    logic [7:0]  v1_addr;
    logic        v1_wr_en;
    logic [31:0] v1_wr_data;

    histogram dut (
        .clk(clk), .rst(rst), .tstart(tstart),
        .v0_addr(v0_addr), .v0_rd_en(v0_rd_en), .v0_rd_data(v0_rd_data),
        .v1_addr(v1_addr), .v1_wr_en(v1_wr_en), .v1_wr_data(v1_wr_data)
    );

    always #5 clk = ~clk;

    // input memory, one-cycle read latency
    logic [7:0] mem [0:4095];
    always @(posedge clk) if (v0_rd_en) v0_rd_data <= mem[v0_addr];

    // result memory and bus monitor
    logic [31:0] res [0:255];
    int cyc = 0;
    int nrd = 0, nwr = 0, rd_err = 0, wr_err = 0;
    int rd_start = 0, wr_start = 0, wr_last = 0, rd_exp = 0, wr_exp = 0;
    logic prv_rd = 1'b0, prv_wr = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        if (v0_rd_en === 1'b1) begin
            if (!prv_rd) begin rd_start = cyc; rd_exp = 0; end
            if (int'(v0_addr) != rd_exp) rd_err++;
            rd_exp++;
            nrd++;
        end
        if (v1_wr_en === 1'b1) begin
            if (!prv_wr) begin wr_start = cyc; wr_exp = 0; end
            if (int'(v1_addr) != wr_exp) wr_err++;
            res[v1_addr] = v1_wr_data;
            wr_exp++;
            wr_last = cyc;
            nwr++;
        end
        prv_rd = (v0_rd_en === 1'b1);
        prv_wr = (v1_wr_en === 1'b1);
    end

    int n_tot = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // 0: addr==3 ? 5 : 1   1: all zero   2: addr[7:0]   3: random, skewed for repeats
    task automatic fill(input int mode);
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] a;
            a = 12'(i);
            case (mode)
                0:       mem[i] = (i == 3) ? 8'd5 : 8'd1;
                1:       mem[i] = 8'd0;
                2:       mem[i] = a[7:0];
                default: mem[i] = (i < 2048) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic run(input string tag, input bit extra);
        int  refc [256];
        int  b_rd, b_wr, b_re, b_we, t0;
        bit  done;
        for (int b = 0; b < 256; b++) refc[b] = 0;
        for (int i = 0; i < 4096; i++) refc[mem[i]]++;
        b_rd = nrd; b_wr = nwr; b_re = rd_err; b_we = wr_err;
        t0 = cyc;
        tstart = 1'b1;
        @(negedge clk);
        tstart = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            tstart = extra && (i == 100 || i == 4200);
            @(negedge clk);
            if (nwr - b_wr >= 256 && v1_wr_en === 1'b0) done = 1'b1;
        end
        tstart = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_nreads"}, 64'(nrd - b_rd), 64'd4096);
        chk({tag, "_nwrites"}, 64'(nwr - b_wr), 64'd256);
        chk({tag, "_rd_order"}, 64'(rd_err - b_re), 64'd0);
        chk({tag, "_wr_order"}, 64'(wr_err - b_we), 64'd0);
        chk({tag, "_rd_lat"}, 64'(rd_start - t0), 64'd1);
        chk({tag, "_wr_lat"}, 64'(wr_start - rd_start), 64'd4097);
        chk({tag, "_wr_span"}, 64'(wr_last - wr_start), 64'd255);
        chk({tag, "_idle_en"}, {62'd0, v0_rd_en, v1_wr_en}, 64'd0);
        for (int b = 0; b < 256; b++)
            chk($sformatf("%s_bin%0d", tag, b), 64'(res[b]), 64'(refc[b]));
    endtask

    initial begin
        int b_rd, b_wr, en_hi;
        bit found;
        rst = 1'b1;
        tstart = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_v0_rd_en", 64'(v0_rd_en), 64'd0);
        chk("rst_v1_wr_en", 64'(v1_wr_en), 64'd0);
        chk("rst_v0_addr", 64'(v0_addr), 64'd0);
        chk("rst_v1_addr", 64'(v1_addr), 64'd0);
        chk("rst_v1_wr_data", 64'(v1_wr_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        fill(0); run("addr3", 1'b0);
        chk("addr3_v1_1", 64'(res[1]), 64'd4095);
        chk("addr3_v1_5", 64'(res[5]), 64'd1);

        fill(1); run("zero", 1'b0);
        chk("zero_v1_0", 64'(res[0]), 64'd4096);

        fill(2); run("ramp", 1'b0);
        chk("ramp_v1_128", 64'(res[128]), 64'd16);

        // back to back, with ignored tstart pulses during the first run
        fill(3); run("b2b_a", 1'b1);
        fill(3); run("b2b_b", 1'b0);

        // reset mid-READ
        fill(3);
        tstart = 1'b1;
        @(negedge clk);
        tstart = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (v0_rd_en === 1'b1 && v0_addr == 12'd2000) found = 1'b1;
        end
        chk("midrst_reach2000", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_en_after", {62'd0, v0_rd_en, v1_wr_en}, 64'd0);
        b_rd = nrd; b_wr = nwr; en_hi = 0;
        repeat (300) begin
            @(negedge clk);
            if (v0_rd_en !== 1'b0 || v1_wr_en !== 1'b0) en_hi++;
        end
        chk("midrst_en_hi", 64'(en_hi), 64'd0);
        chk("midrst_nwrites", 64'(nwr - b_wr), 64'd0);
        chk("midrst_nreads", 64'(nrd - b_rd), 64'd0);
        fill(3); run("post_rst", 1'b0);

        // tstart and rst on the same edge
        rst = 1'b1;
        tstart = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tstart = 1'b0;
        b_rd = nrd;
        repeat (20) @(negedge clk);
        chk("rst_tstart_nreads", 64'(nrd - b_rd), 64'd0);
        chk("rst_tstart_rd_en", 64'(v0_rd_en), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
